// File: rtl/memory_pkg.sv
// Shared definitions for the memory group: default geometry, a ceil-log2
// helper and the width rule for occupancy counters.
package memory_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    // Ceiling log2, evaluated at elaboration time for pointer widths.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    // An occupancy counter must also represent the "completely full" value,
    // so it needs one bit more than a pointer.
    function automatic int count_width(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register array with a synchronous write port, an
// asynchronous read port and a synchronous clear on reset.
module fifo_mem
    import memory_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage: cleared on reset so the read port shows zero after power-up.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read gives first-word fall-through at the FIFO level.
    assign rdata = mem[raddr];

endmodule

// File: rtl/latch_fifo.sv
// Small first-word-fall-through FIFO placed after the latch stage.
//
// Handshake: a word moves on a rising edge only when enable is 1 and both
// sides agree in that cycle -- push when in_valid & in_ready, pop when
// out_valid & out_ready. in_ready and out_valid are decoded from registered
// occupancy only, so neither depends combinationally on in_valid or
// out_ready. A full FIFO refuses a push even if a pop happens in the same
// cycle; an empty FIFO never pops.
module latch_fifo
    import memory_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int ADDR_W  = clog2(DEPTH),
    localparam int COUNT_W = count_width(ADDR_W)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    input  logic               out_ready,
    output logic [COUNT_W-1:0] count,
    output logic               full,
    output logic               empty,
    output logic               overflow
);

    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [COUNT_W-1:0] count_q;
    logic               overflow_q;
    logic               push;
    logic               pop;

    // Status flags come straight from the registered count.
    assign full      = (count_q == COUNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign count     = count_q;
    assign overflow  = overflow_q;

    assign push = enable & in_valid & in_ready;
    assign pop  = enable & out_valid & out_ready;

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            // Pointers wrap naturally at ADDR_W bits since DEPTH is a power of two.
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + COUNT_W'(1);
                2'b01:   count_q <= count_q - COUNT_W'(1);
                default: count_q <= count_q;
            endcase
            // Only an enabled attempt counts as a lost word.
            if (enable && in_valid && full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_mem (
        .clock(clock),
        .reset(reset),
        .we   (push),
        .waddr(wr_ptr),
        .wdata(in_data),
        .raddr(rd_ptr),
        .rdata(out_data)
    );

endmodule

// File: tb/tb_latch_fifo.sv
// Bench for latch_fifo: a driver issues cycles and predicts accepted words
// from a queue-based model; a negedge monitor checks status and every
// handshaken output word against the expected queue.
module tb_latch_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clock;
    logic             reset;
    logic             enable;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [2:0]       count;
    logic             full;
    logic             empty;
    logic             overflow;

    latch_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    // Clock and reset-related bookkeeping.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: contents in arrival order, plus the sticky error flag.
    logic [WIDTH-1:0] model_q[$];
    logic             model_ovf;
    // Scoreboard: words the model says leave the FIFO on the coming edge.
    logic [WIDTH-1:0] exp_q[$];

    int  n_cmp;
    int  n_err;
    bit  checking;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver: apply one cycle of inputs, predict its effect, advance the model.
    task automatic cycle(input logic r, input logic e, input logic iv,
                         input logic [WIDTH-1:0] d, input logic ordy);
        bit do_push;
        bit do_pop;
        bit set_ovf;
        reset     = r;
        enable    = e;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        do_push = !r && e && iv && (model_q.size() < DEPTH);
        do_pop  = !r && e && ordy && (model_q.size() > 0);
        set_ovf = !r && e && iv && (model_q.size() == DEPTH);
        if (do_pop) exp_q.push_back(model_q[0]);
        @(posedge clock);
        #1;
        if (checking && exp_q.size() != 0) begin
            chk("missed_pop", 32'(exp_q.size()), 32'd0);
        end
        exp_q.delete();
        if (r) begin
            model_q.delete();
            model_ovf = 1'b0;
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(d);
            if (set_ovf) model_ovf = 1'b1;
        end
    endtask

    // Monitor: status against the model and output words against the scoreboard.
    always @(negedge clock) begin
        if (checking) begin
            chk("count", 32'(count), 32'(model_q.size()));
            chk("empty", 32'(empty), 32'(model_q.size() == 0));
            chk("full", 32'(full), 32'(model_q.size() == DEPTH));
            chk("in_ready", 32'(in_ready), 32'(model_q.size() != DEPTH));
            chk("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
            chk("overflow", 32'(overflow), 32'(model_ovf));
            if (model_q.size() != 0) chk("out_front", 32'(out_data), 32'(model_q[0]));
            if (!reset && enable && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    chk("pop_data", 32'(out_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        checking = 1'b0;
        model_ovf = 1'b0;

        // Reset while a push is offered: nothing must be stored.
        cycle(1, 1, 1, 8'hAA, 0);
        checking = 1'b1;
        chk("reset_out_data", 32'(out_data), 32'h0);

        // Fill with 1..4, then one refused push of 5 sets overflow.
        for (int i = 1; i <= 4; i++) cycle(0, 1, 1, WIDTH'(i), 0);
        cycle(0, 1, 1, 8'd5, 0);
        // Drain; overflow must remain set throughout.
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 8'h00, 1);
        cycle(0, 1, 0, 8'h00, 0);

        // Reset clears overflow; then concurrent push/pop around the wrap.
        cycle(1, 1, 0, 8'h00, 0);
        cycle(0, 1, 1, 8'd1, 0);
        cycle(0, 1, 1, 8'd2, 0);
        for (int i = 3; i < 13; i++) cycle(0, 1, 1, WIDTH'(i), 1);

        // Enable gating with two entries stored.
        cycle(1, 1, 0, 8'h00, 0);
        cycle(0, 1, 1, 8'h11, 0);
        cycle(0, 1, 1, 8'h22, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 8'h99, 1);
        cycle(0, 1, 1, 8'h33, 1);

        // Reset mid-operation with three entries, then a fresh push of 7.
        cycle(0, 1, 1, 8'h44, 0);
        cycle(1, 1, 1, 8'h55, 0);
        cycle(0, 1, 1, 8'h07, 0);
        chk("post_reset_data", 32'(out_data), 32'h07);
        cycle(0, 1, 0, 8'h00, 1);

        // Randomized traffic with occasional enable drops and resets.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 60) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0,
                  1'($urandom_range(0, 1)),
                  WIDTH'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)));
        end

        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
